// File: rtl/bmp_pkg.sv
// Shared types and helpers for the BMP pixel-array writer.
package bmp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WR_B,
    S_WR_G,
    S_WR_R,
    S_PAD,
    S_DONE
  } state_t;

  localparam int HDR_BYTES_DEF = 54;
  localparam int BYTES_PER_PIX = 3;

  // Bytes of zero padding needed to bring a row of n bytes to a 4-byte multiple.
  function automatic logic [1:0] bmp_pad(input int unsigned n);
    return 2'((4 - (n % 4)) % 4);
  endfunction

endpackage

// File: rtl/bmp_pixel_writer_if.sv
// Pixel-fetch handshake and byte-write bus between the writer, the frame
// buffer and the output memory.
interface bmp_pixel_writer_if;
  logic        pix_req;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [23:0] addr;
  logic        wren;
  logic [15:0] wrdata;

  modport master (
    output pix_req, pix_x, pix_y, addr, wren, wrdata,
    input  pix_valid, pix_data
  );

  modport slave (
    input  pix_req, pix_x, pix_y, addr, wren, wrdata,
    output pix_valid, pix_data
  );
endinterface

// File: rtl/bmp_row_ctr.sv
// Window scan counter: x runs left to right, y runs top row down to the
// bottom bound, matching the bottom-up row order of a BMP pixel array.
module bmp_row_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [10:0] x_first,
  input  logic [10:0] x_last,
  input  logic [10:0] y_first,
  input  logic [10:0] y_last,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        last_x,
  output logic        last_y
);

  logic [10:0] x_first_q;
  logic [10:0] x_last_q;
  logic [10:0] y_last_q;

  // Position counter; wraps x back to the left edge and moves one row down.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= x_first;
      y <= y_first;
    end else if (step) begin
      if (last_x) begin
        x <= x_first_q;
        y <= y - 11'd1;
      end else begin
        x <= x + 11'd1;
      end
    end
  end

  // Window bounds held for the whole frame.
  always_ff @(posedge clk) begin
    if (load) begin
      x_first_q <= x_first;
      x_last_q  <= x_last;
      y_last_q  <= y_last;
    end
  end

  assign last_x = (x == x_last_q);
  assign last_y = (y == y_last_q);

endmodule

// File: rtl/bmp_pixel_writer.sv
// BMP pixel-array writer: fetches the cropped window pixel by pixel and
// writes B,G,R bytes bottom-up with per-row zero padding after the header.
// Optional macro BMP_PIX_TIMEOUT_EN: bound the pixel wait to TIMEOUT cycles,
// substitute a black pixel and raise sticky err on expiry.
module bmp_pixel_writer
  import bmp_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'd0,
  parameter int          HDR_BYTES = HDR_BYTES_DEF,
  parameter int          TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               done,
  input  logic [10:0]        xMin,
  input  logic [10:0]        xMax,
  input  logic [10:0]        yMin,
  input  logic [10:0]        yMax,
  bmp_pixel_writer_if.master pif,
  output logic [23:0]        bytes_written,
  output logic               err
);

  state_t      state_q, state_n;
  logic [10:0] x, y;
  logic        last_x, last_y;
  logic        load, step;
  logic        empty;
  logic [10:0] w;
  logic [1:0]  pad_calc, pad_q;
  logic [1:0]  pad_left_q, pad_left_n;
  logic [23:0] pix_q, pix_n;
  logic [23:0] bw_q, bw_n;
  logic        wr_n;
  logic [7:0]  byte_n;
  logic        done_q, pix_req_q, wren_q;
  logic [15:0] wrdata_q;
  logic [23:0] addr_q;

`ifdef BMP_PIX_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wcnt_q, wcnt_n;
  logic        err_q, err_n;
`endif

  assign empty    = (xMax <= xMin) || (yMax <= yMin);
  assign w        = xMax - xMin;
  assign pad_calc = bmp_pad(32'(BYTES_PER_PIX) * 32'(w));

  bmp_row_ctr u_row_ctr (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .x_first (xMin),
    .x_last  (xMax - 11'd1),
    .y_first (yMax - 11'd1),
    .y_last  (yMin),
    .x       (x),
    .y       (y),
    .last_x  (last_x),
    .last_y  (last_y)
  );

  // Next-state, row/pad sequencing and next byte to present on the bus.
  always_comb begin
    state_n    = state_q;
    load       = 1'b0;
    step       = 1'b0;
    pix_n      = pix_q;
    pad_left_n = pad_left_q;
    bw_n       = wren_q ? bw_q + 24'd1 : bw_q;
`ifdef BMP_PIX_TIMEOUT_EN
    wcnt_n     = wcnt_q;
    err_n      = err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          bw_n = '0;
`ifdef BMP_PIX_TIMEOUT_EN
          err_n = 1'b0;
`endif
          if (empty) begin
            state_n = S_DONE;
          end else begin
            load    = 1'b1;
            state_n = S_REQ;
          end
        end
      end
      S_REQ: begin
        state_n = S_WAIT;
`ifdef BMP_PIX_TIMEOUT_EN
        wcnt_n  = '0;
`endif
      end
      S_WAIT: begin
        if (pif.pix_valid) begin
          pix_n   = pif.pix_data;
          state_n = S_WR_B;
        end
`ifdef BMP_PIX_TIMEOUT_EN
        else if (wcnt_q == WAIT_LAST) begin
          // Missing pixel is written as black so the file stays well formed.
          pix_n   = '0;
          err_n   = 1'b1;
          state_n = S_WR_B;
        end else begin
          wcnt_n = wcnt_q + 16'd1;
        end
`endif
      end
      S_WR_B: state_n = S_WR_G;
      S_WR_G: state_n = S_WR_R;
      S_WR_R: begin
        if (!last_x) begin
          step    = 1'b1;
          state_n = S_REQ;
        end else if (pad_q != 2'd0) begin
          pad_left_n = pad_q;
          state_n    = S_PAD;
        end else if (last_y) begin
          state_n = S_DONE;
        end else begin
          step    = 1'b1;
          state_n = S_REQ;
        end
      end
      S_PAD: begin
        pad_left_n = pad_left_q - 2'd1;
        if (pad_left_q == 2'd1) begin
          if (last_y) begin
            state_n = S_DONE;
          end else begin
            step    = 1'b1;
            state_n = S_REQ;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    wr_n = (state_n == S_WR_B) || (state_n == S_WR_G) ||
           (state_n == S_WR_R) || (state_n == S_PAD);
    case (state_n)
      S_WR_B:  byte_n = pix_n[7:0];
      S_WR_G:  byte_n = pix_n[15:8];
      S_WR_R:  byte_n = pix_n[23:16];
      default: byte_n = 8'h00;
    endcase
  end

  // State and registered bus outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      pix_req_q  <= 1'b0;
      wren_q     <= 1'b0;
      wrdata_q   <= '0;
      addr_q     <= '0;
      bw_q       <= '0;
      pad_left_q <= '0;
    end else begin
      state_q    <= state_n;
      done_q     <= (state_n == S_DONE);
      pix_req_q  <= (state_n == S_REQ) || (state_n == S_WAIT);
      wren_q     <= wr_n;
      wrdata_q   <= {8'h00, byte_n};
      bw_q       <= bw_n;
      pad_left_q <= pad_left_n;
      if (wr_n) addr_q <= BASE_ADDR + 24'(HDR_BYTES) + bw_n;
    end
  end

  // Captured pixel and per-frame row padding.
  always_ff @(posedge clk) begin
    pix_q <= pix_n;
    if (load) pad_q <= pad_calc;
  end

`ifdef BMP_PIX_TIMEOUT_EN
  // Wait-cycle counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_n;
      err_q  <= err_n;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign done          = done_q;
  assign pif.pix_req   = pix_req_q;
  assign pif.pix_x     = x;
  assign pif.pix_y     = y;
  assign pif.addr      = addr_q;
  assign pif.wren      = wren_q;
  assign pif.wrdata    = wrdata_q;
  assign bytes_written = bw_q;

endmodule

// File: tb/tb_bmp_pixel_writer.sv
// Randomized self-checking bench for bmp_pixel_writer against a
// frame-level model of the expected BMP pixel array.
module tb_bmp_pixel_writer;

  localparam int TO = 4;
`ifdef BMP_PIX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        done;
  logic [10:0] xMin, xMax, yMin, yMax;
  logic [23:0] bytes_written;
  logic        err;

  bmp_pixel_writer_if pif ();

  bmp_pixel_writer #(
    .BASE_ADDR (24'd0),
    .HDR_BYTES (54),
    .TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .done          (done),
    .xMin          (xMin),
    .xMax          (xMax),
    .yMin          (yMin),
    .yMax          (yMax),
    .pif           (pif),
    .bytes_written (bytes_written),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Frame buffer contents
  logic [31:0] fb_seed;
  bit          fb_const_en;
  logic [23:0] fb_const;

  function automatic logic [23:0] fb_pixel(input logic [10:0] px, input logic [10:0] py);
    logic [31:0] h;
    if (fb_const_en) return fb_const;
    h = ({21'd0, px} * 32'd2654435761) ^ ({21'd0, py} * 32'd40503) ^ fb_seed;
    return h[23:0];
  endfunction

  // Responder / monitor state
  int          delay_cyc;
  int          to_pix_idx;
  int          req_idx;
  int          age;
  bit          stray;
  bit          hit;
  logic [10:0] cur_x, cur_y;
  logic [21:0] req_q[$];
  logic [23:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          req_run_max;
  int          overlap_cnt;
  int          unstable_cnt;

  // Frame buffer responder plus bus monitor, sampling mid-cycle.
  initial begin
    pif.pix_valid = 1'b0;
    pif.pix_data  = '0;
    age = 0;
    forever begin
      @(negedge clk);
      if (pif.wren) begin
        wr_addr_q.push_back(pif.addr);
        wr_data_q.push_back(pif.wrdata);
        if (pif.pix_req) overlap_cnt++;
      end
      if (pif.pix_req) begin
        if (age == 0) begin
          cur_x = pif.pix_x;
          cur_y = pif.pix_y;
          req_q.push_back({pif.pix_x, pif.pix_y});
        end else if (pif.pix_x !== cur_x || pif.pix_y !== cur_y) begin
          unstable_cnt++;
        end
        hit = (age == delay_cyc) && (req_idx != to_pix_idx);
        pif.pix_valid = hit || stray;
        pif.pix_data  = hit ? fb_pixel(cur_x, cur_y) : 24'($urandom);
        age++;
        if (age > req_run_max) req_run_max = age;
      end else begin
        if (age != 0) req_idx++;
        age = 0;
        pif.pix_valid = stray;
        pif.pix_data  = 24'($urandom);
      end
    end
  end

  task automatic run_frame(input logic [10:0] x0, input logic [10:0] x1,
                           input logic [10:0] y0, input logic [10:0] y1,
                           input int dly, input int to_idx,
                           input bit stray_at_start, input bit mid_start);
    logic [7:0]  exp_b[$];
    logic [21:0] exp_req[$];
    logic [23:0] p;
    int  W, H, pad, exp_bw, pix_i, n, exp_run;
    bit  tmo, any_tmo, is_empty;

    // Reference: expected byte stream, request order and counts
    is_empty = (x1 <= x0) || (y1 <= y0);
    W = int'(x1) - int'(x0);
    H = int'(y1) - int'(y0);
    pix_i = 0; exp_run = 0; any_tmo = 1'b0; exp_bw = 0;
    if (!is_empty) begin
      pad = (4 - ((3 * W) % 4)) % 4;
      exp_bw = H * (3 * W + pad);
      for (int yy = int'(y1) - 1; yy >= int'(y0); yy--) begin
        for (int xx = int'(x0); xx < int'(x1); xx++) begin
          tmo = (pix_i == to_idx) || (TMO_EN && dly > TO);
          any_tmo |= tmo;
          p = tmo ? 24'h0 : fb_pixel(11'(xx), 11'(yy));
          if ((tmo ? TO + 1 : dly + 1) > exp_run) exp_run = tmo ? TO + 1 : dly + 1;
          exp_req.push_back({11'(xx), 11'(yy)});
          exp_b.push_back(p[7:0]);
          exp_b.push_back(p[15:8]);
          exp_b.push_back(p[23:16]);
          pix_i++;
        end
        while (exp_b.size() % 4 != 0) exp_b.push_back(8'h00);
      end
    end

    delay_cyc = dly; to_pix_idx = to_idx; req_idx = 0;
    req_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    req_run_max = 0; overlap_cnt = 0; unstable_cnt = 0;

    @(posedge clk); #1;
    xMin = x0; xMax = x1; yMin = y0; yMax = y1;
    start = 1'b1; stray = stray_at_start;
    @(posedge clk); #1;
    start = 1'b0; stray = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (mid_start && n == 3) begin
        start = 1'b1; xMin = x0 + 11'd1;
      end else begin
        start = 1'b0;
      end
    end
    check_eq("done_seen", 32'(done), 32'd1);
    if (is_empty) check_eq("empty_done_lat", 32'(n <= 1), 32'd1);
    repeat (3) @(posedge clk);
    #1;

    check_eq("wr_count", 32'(wr_addr_q.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < wr_addr_q.size(); i++) begin
      check_eq($sformatf("wr_addr[%0d]", i), 32'(wr_addr_q[i]), 32'(54 + i));
      check_eq($sformatf("wr_data[%0d]", i), 32'(wr_data_q[i]), {24'h0, exp_b[i]});
    end
    check_eq("req_count", 32'(req_q.size()), 32'(exp_req.size()));
    for (int i = 0; i < exp_req.size() && i < req_q.size(); i++)
      check_eq($sformatf("req_xy[%0d]", i), 32'(req_q[i]), 32'(exp_req[i]));
    check_eq("bytes_written", 32'(bytes_written), 32'(exp_bw));
    check_eq("err", 32'(err), 32'(any_tmo));
    check_eq("req_run_max", 32'(req_run_max), 32'(exp_run));
    check_eq("wren_during_req", 32'(overlap_cnt), 32'd0);
    check_eq("coord_stable", 32'(unstable_cnt), 32'd0);
    check_eq("done_hold", 32'(done), 32'd1);
  endtask

  initial begin
    int n, n_before;
    logic [10:0] rx, ry;
    rst = 1'b1; start = 1'b0; stray = 1'b0;
    xMin = '0; xMax = '0; yMin = '0; yMax = '0;
    delay_cyc = 1; to_pix_idx = -1; req_idx = 0;
    req_run_max = 0; overlap_cnt = 0; unstable_cnt = 0;
    fb_seed = $urandom; fb_const_en = 1'b0; fb_const = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_wren", 32'(pif.wren), 32'd0);
    check_eq("rst_pix_req", 32'(pif.pix_req), 32'd0);
    check_eq("rst_addr", 32'(pif.addr), 32'd0);
    check_eq("rst_bw", 32'(bytes_written), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Two-by-two window with 2 pad bytes per row
    run_frame(11'd10, 11'd12, 11'd5, 11'd7, 1, -1, 1'b0, 1'b0);

    // Single row, constant pixel, no padding
    fb_const_en = 1'b1; fb_const = 24'h112233;
    run_frame(11'd0, 11'd4, 11'd0, 11'd1, 1, -1, 1'b0, 1'b0);
    fb_const_en = 1'b0;

    // Empty windows
    run_frame(11'd100, 11'd100, 11'd5, 11'd7, 1, -1, 1'b0, 1'b0);
    run_frame(11'd5, 11'd8, 11'd9, 11'd3, 1, -1, 1'b0, 1'b0);

    // Slow frame buffer
    run_frame(11'd30, 11'd33, 11'd40, 11'd42, 7, -1, 1'b0, 1'b0);

    // Stray valid alongside start, and start pulsed mid-frame
    run_frame(11'd200, 11'd203, 11'd0, 11'd2, 2, -1, 1'b1, 1'b1);

    // Right edge of the coordinate space
    run_frame(11'd2044, 11'd2047, 11'd1, 11'd3, 1, -1, 1'b0, 1'b0);

`ifdef BMP_PIX_TIMEOUT_EN
    // Second pixel never answered
    run_frame(11'd20, 11'd23, 11'd7, 11'd8, 1, 1, 1'b0, 1'b0);
`endif

    // Reset in the middle of a frame
    delay_cyc = 1; to_pix_idx = -1; req_idx = 0;
    wr_addr_q.delete(); wr_data_q.delete(); req_q.delete();
    @(posedge clk); #1;
    xMin = 11'd10; xMax = 11'd14; yMin = 11'd3; yMax = 11'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (wr_addr_q.size() < 5 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("rst_mid_reached", 32'(wr_addr_q.size() >= 5), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rstm_wren", 32'(pif.wren), 32'd0);
    check_eq("rstm_done", 32'(done), 32'd0);
    check_eq("rstm_pix_req", 32'(pif.pix_req), 32'd0);
    check_eq("rstm_pix_xy", {10'd0, pif.pix_x, pif.pix_y}, 32'd0);
    check_eq("rstm_addr", 32'(pif.addr), 32'd0);
    check_eq("rstm_wrdata", 32'(pif.wrdata), 32'd0);
    check_eq("rstm_bw", 32'(bytes_written), 32'd0);
    check_eq("rstm_err", 32'(err), 32'd0);
    rst = 1'b0;
    n_before = wr_addr_q.size();
    repeat (6) @(posedge clk);
    #1;
    check_eq("rstm_no_writes", 32'(wr_addr_q.size()), 32'(n_before));
    check_eq("rstm_idle_done", 32'(done), 32'd0);
    run_frame(11'd10, 11'd14, 11'd3, 11'd5, 1, -1, 1'b0, 1'b0);

    // Randomized windows
    for (int k = 0; k < 6; k++) begin
      rx = 11'($urandom_range(0, 2040));
      ry = 11'($urandom_range(0, 1000));
      fb_seed = $urandom;
      run_frame(rx, rx + 11'($urandom_range(1, 6)), ry, ry + 11'($urandom_range(1, 3)),
                int'($urandom_range(1, 3)), -1, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bmp_pixel_writer.md
Name: bmp_pixel_writer

Overview:
- Downstream neighbour of the BMP header writer; runs after the header stage asserts done.
- Reads the cropped window [xMin,xMax) x [yMin,yMax) from the frame buffer, one 24-bit pixel per request.
- Writes the BMP pixel array into the same byte-addressed output memory, starting at offset HDR_BYTES.
- Rows are written bottom-up in B,G,R byte order, and each row is zero-padded to a 4-byte multiple.

Parameters:
- BASE_ADDR, 0: byte address of BMP byte 0 in the output memory.
- HDR_BYTES, 54: header length; the pixel array starts at BASE_ADDR+HDR_BYTES.
- TIMEOUT, 255: maximum cycles spent waiting for pix_valid; used only when BMP_PIX_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a frame.
- done  out  1  level; high while in S_DONE.
- xMin, xMax, yMin, yMax  in  11 each  window bounds; max bounds exclusive; sampled on accepted start.
- pix_req  out  1  pixel fetch request.
- pix_x, pix_y  out  11 each  coordinate of the requested pixel.
- pix_valid  in  1  pixel data valid.
- pix_data  in  24  pixel as {R[23:16],G[15:8],B[7:0]}.
- addr  out  24  output-memory byte address.
- wren  out  1  write enable; one byte per cycle.
- wrdata  out  16  write data; [7:0] is the byte, [15:8] is always 0.
- bytes_written  out  24  pixel-array bytes written so far, padding included.
- err  out  1  sticky timeout flag; constant 0 when the feature is off.

Behaviour:
- Reset (synchronous, rst=1):
  - state goes to S_IDLE.
  - done=0, pix_req=0, pix_x=0, pix_y=0, addr=0, wren=0, wrdata=0, bytes_written=0, err=0.
  - Reset mid-frame aborts immediately; no further writes occur.
- Start acceptance:
  - start is accepted in S_IDLE or S_DONE; start in any other state is ignored.
  - On acceptance, latch W=xMax-xMin and H=yMax-yMin as 11-bit values.
  - If xMax<=xMin or yMax<=yMin, go directly to S_DONE with no writes.
  - Otherwise: pad=(4-((3*W) mod 4)) mod 4, x=xMin, y=yMax-1, bytes_written=0, clear err, go to S_REQ.
- States and transitions:
  - S_IDLE: all outputs inactive.
  - S_REQ: drive pix_req=1, pix_x=x, pix_y=y; go to S_WAIT.
  - S_WAIT:
    - Hold pix_req=1 with a stable coordinate.
    - When pix_valid=1, capture pix_data, drop pix_req the same edge, go to S_WR_B.
    - pix_valid is ignored in every other state.
  - S_WR_B, S_WR_G, S_WR_R: wren=1, one byte per state, B first.
  - After S_WR_R:
    - x<xMax-1: x++, go to S_REQ.
    - x==xMax-1 and pad>0: go to S_PAD.
    - Row done and y>yMin: x=xMin, y--, go to S_REQ.
    - Row done and y==yMin: go to S_DONE.
  - S_PAD: write pad bytes of 0x00, one per cycle, then follow the same row-done rules.
  - S_DONE: done=1 and wren=0; stay until the next start.
- Addressing and counting:
  - addr=BASE_ADDR+HDR_BYTES+bytes_written, a 24-bit sum that wraps modulo 2^24.
  - bytes_written increments on every wren cycle.
  - Final bytes_written is H*(3*W+pad).
- Outputs are registered. wren/addr/wrdata change only on clk edges.
- Latency: 3 + read-latency cycles per pixel at minimum.
- pix_valid asserted in the same cycle as start has no effect.

Optional Feature:
- BMP_PIX_TIMEOUT_EN defined:
  - A wait counter runs in S_WAIT.
  - After TIMEOUT cycles with no pix_valid: drop pix_req, set err=1 (sticky until the next accepted start or rst), write 0x00,0x00,0x00 for that pixel, continue.
- BMP_PIX_TIMEOUT_EN undefined: S_WAIT waits forever; err is tied to 0.

Decomposition:
- Package bmp_pkg:
  - state enum.
  - HDR_BYTES_DEF=54.
  - BYTES_PER_PIX=3.
  - pad function: (4-(n mod 4)) mod 4.
- Sub-module bmp_row_ctr:
  - Holds the x/y window counter (x ascending, y descending).
  - Signals: step in; last_x and last_y out.
  - The top level keeps the FSM and the byte writer.

Test Plan:
- xMin=10,xMax=12,yMin=5,yMax=7, pix_valid 1 cycle after req -> requests (10,6),(11,6),(10,5),(11,5).
  - 16 writes at addr 54..69; bytes 60,61,68,69 = 0x00.
  - done=1, bytes_written=16.
- W=4,H=1, pixel 0x112233 -> writes 0x33,0x22,0x11 per pixel, no pad; bytes_written=12.
- xMax==xMin=100 -> done=1 within 2 cycles of start, zero wren cycles, bytes_written=0.
- pix_valid delayed 7 cycles -> pix_req held for 8 cycles, pix_x/pix_y stable, no wren during the wait, data correct.
- rst asserted after the 5th write, then released, then start with the same window -> wren=0 the cycle after rst, all outputs at reset values, second run writes from addr 54.
- With BMP_PIX_TIMEOUT_EN, TIMEOUT=4, pix_valid never asserted for the 2nd pixel -> pix_req drops after 4 cycles, err=1, 3 zero bytes written, frame completes with done=1.
